ad_serial_tx: RTL and testbench

//  Synthesizable slave/transmitter end of the AD-style serial ADC link (cs_n/sclk/sdata).

---
 rtl/ad_serial_tx_pkg.sv | 16 +
 rtl/ad_serial_sync.sv | 30 +++
 rtl/ad_serial_tx.sv | 143 ++++++++++++++
 tb/tb_ad_serial_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_serial_tx_pkg.sv
// Constants shared by the AD serial link transmitter and master: state encoding and counter sizing.
package ad_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ZERO = 2'd1,
    ST_DATA = 2'd2,
    ST_TAIL = 2'd3
  } tx_state_t;

  // bit_cnt must hold lead_z + data_w without wrapping so it can saturate there
  function automatic int bit_cnt_w(input int lead_z, input int data_w);
    return $clog2(lead_z + data_w + 1);
  endfunction

endpackage

// File: rtl/ad_serial_sync.sv
// Multi-stage synchronizer for one async pin plus a delay flop for edge detection.
// Synchronized level appears STG cycles after the pin; lvl_d trails it by one cycle.
module ad_serial_sync
  import ad_serial_tx_pkg::*;
#(
  parameter int   STG  = 2,
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic lvl_d
);

  logic [STG-1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= {STG{INIT}};
      lvl_d <= INIT;
    end else begin
      sync  <= {sync[STG-2:0], din};
      lvl_d <= sync[STG-1];
    end
  end

  assign lvl = sync[STG-1];

endmodule

// File: rtl/ad_serial_tx.sv
// Slave end of the cs_n/sclk/sdata ADC link: shifts LEAD_Z zeros then a DATA_W sample, MSB first.
// Pin edges act SYNC_STG+1 mclk0 cycles later; one-entry sample buffer, smp_rdy low while it is full.
module ad_serial_tx
  import ad_serial_tx_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int LEAD_Z   = 4,
  parameter int SYNC_STG = 2
) (
  input  logic              mclk0,
  input  logic              hrst,
  input  logic              cs_n,
  input  logic              sclk,
  output logic              sdata,
  output logic              sdata_oe,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_vld,
  output logic              smp_rdy,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              underrun
);

  localparam int CNT_W = bit_cnt_w(LEAD_Z, DATA_W);
  localparam logic [CNT_W-1:0] CNT_ZLAST = CNT_W'(LEAD_Z - 1);
  localparam logic [CNT_W-1:0] CNT_DLAST = CNT_W'(LEAD_Z + DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LEAD_Z + DATA_W);

  logic cs_s, cs_d, sclk_s, sclk_d;
  logic cs_fall, cs_rise, sclk_fall;

  ad_serial_sync #(.STG(SYNC_STG), .INIT(1'b1)) u_cs_sync (
    .clk   (mclk0),
    .rst   (hrst),
    .din   (cs_n),
    .lvl   (cs_s),
    .lvl_d (cs_d)
  );

  ad_serial_sync #(.STG(SYNC_STG), .INIT(1'b1)) u_sclk_sync (
    .clk   (mclk0),
    .rst   (hrst),
    .din   (sclk),
    .lvl   (sclk_s),
    .lvl_d (sclk_d)
  );

  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  tx_state_t         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg, last_smp, buf_dat;
  logic              buf_full, start, accept;

  assign start   = (state == ST_IDLE) && cs_fall;
  assign accept  = smp_vld && !buf_full;
  assign smp_rdy = !buf_full;

  // A word arriving on the start cycle with the buffer empty is kept for the next frame
  always_ff @(posedge mclk0 or posedge hrst) begin
    if (hrst) begin
      buf_full <= 1'b0;
      buf_dat  <= '0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_dat  <= smp_data;
    end else if (start) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge mclk0 or posedge hrst) begin
    if (hrst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      last_smp    <= '0;
      sdata       <= 1'b0;
      sdata_oe    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            if (buf_full) begin
              shift_reg <= buf_dat;
              last_smp  <= buf_dat;
            end else begin
              shift_reg <= last_smp;
              underrun  <= 1'b1;
            end
            sdata    <= 1'b0;
            sdata_oe <= 1'b1;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            state    <= ST_ZERO;
          end
        end
        ST_ZERO, ST_DATA: begin
          if (cs_rise) begin
            frame_abort <= 1'b1;
            sdata       <= 1'b0;
            sdata_oe    <= 1'b0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else if (sclk_fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (state == ST_DATA && bit_cnt == CNT_DLAST) begin
              sdata <= 1'b0;
              state <= ST_TAIL;
            end else if (state == ST_DATA || bit_cnt == CNT_ZLAST) begin
              sdata     <= shift_reg[DATA_W-1];
              shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
              state     <= ST_DATA;
            end
          end
        end
        ST_TAIL: begin
          if (cs_rise) begin
            frame_done <= 1'b1;
            sdata      <= 1'b0;
            sdata_oe   <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (sclk_fall && bit_cnt != CNT_MAX) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad_serial_tx.sv
// Randomized scoreboard bench: a bench-side master clocks frames, a monitor checks each frame end.
module tb_ad_serial_tx;

  localparam int DATA_W = 12;
  localparam int LEAD_Z = 4;
  localparam int FRAME  = LEAD_Z + DATA_W;

  logic              mclk0 = 1'b0;
  logic              hrst = 1'b1;
  logic              cs_n = 1'b1;
  logic              sclk = 1'b1;
  logic [DATA_W-1:0] smp_data = '0;
  logic              smp_vld = 1'b0;
  logic sdata, sdata_oe, smp_rdy, busy, frame_done, frame_abort, underrun;

  int n_tests = 0;
  int n_fail  = 0;
  int half    = 5;
  int ucnt    = 0;

  always #5 mclk0 = ~mclk0;

  ad_serial_tx #(.DATA_W(DATA_W), .LEAD_Z(LEAD_Z), .SYNC_STG(2)) dut (
    .mclk0       (mclk0),
    .hrst        (hrst),
    .cs_n        (cs_n),
    .sclk        (sclk),
    .sdata       (sdata),
    .sdata_oe    (sdata_oe),
    .smp_data    (smp_data),
    .smp_vld     (smp_vld),
    .smp_rdy     (smp_rdy),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .underrun    (underrun)
  );

  typedef struct {
    bit          is_abort;
    int          under;
    logic [31:0] bits;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] obs_q[$];
  exp_t        mon_e;
  logic [31:0] mon_o;

  // Reference model of the sample path: optional buffered word plus last-sent word
  logic [DATA_W-1:0] m_buf  = '0;
  logic [DATA_W-1:0] m_last = '0;
  bit                m_full = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Bits a master sees when sampling just before each of n sclk falls
  function automatic logic [31:0] exp_bits(input logic [DATA_W-1:0] w, input int n);
    logic [31:0] r;
    logic        b;
    r = '0;
    for (int i = 0; i < n; i++) begin
      b = (i >= LEAD_Z && i < FRAME) ? w[DATA_W-1-(i-LEAD_Z)] : 1'b0;
      r = {r[30:0], b};
    end
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge mclk0);
    #1;
  endtask

  task automatic load(input logic [DATA_W-1:0] w);
    int t;
    t = 0;
    while (!smp_rdy && t < 200) begin
      tick(1);
      t++;
    end
    check("load_rdy", smp_rdy, 1);
    smp_data = w;
    smp_vld  = 1'b1;
    tick(1);
    smp_vld = 1'b0;
    m_buf   = w;
    m_full  = 1'b1;
  endtask

  task automatic frame(input int nfall, input bit vld_at_start, input logic [DATA_W-1:0] w_start);
    logic [DATA_W-1:0] word;
    logic [31:0]       cap;
    int                under;
    cap = '0;
    if (m_full) begin
      word   = m_buf;
      m_last = m_buf;
      m_full = 1'b0;
      under  = 0;
    end else begin
      word  = m_last;
      under = 1;
    end
    cs_n = 1'b0;
    if (vld_at_start) begin
      tick(2);
      check("rdy_at_start", smp_rdy, 1);
      smp_data = w_start;
      smp_vld  = 1'b1;
      tick(1);
      smp_vld = 1'b0;
      m_buf   = w_start;
      m_full  = 1'b1;
    end
    tick(half);
    for (int i = 0; i < nfall; i++) begin
      cap = {cap[30:0], sdata};
      if (i == 0) begin
        check("oe_in_frame", sdata_oe, 1);
        check("busy_in_frame", busy, 1);
      end
      sclk = 1'b0;
      tick(half);
      sclk = 1'b1;
      tick(half);
    end
    exp_q.push_back('{is_abort: (nfall < FRAME), under: under, bits: exp_bits(word, nfall)});
    obs_q.push_back(cap);
    cs_n = 1'b1;
    tick(3);
    check("busy_drop", busy, 0);
    check("oe_drop", sdata_oe, 0);
    tick(3);
  endtask

  always @(negedge mclk0) begin
    if (hrst) begin
      ucnt = 0;
    end else begin
      if (underrun) ucnt++;
      if (frame_done || frame_abort) begin
        if (exp_q.size() == 0 || obs_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: done=%0b abort=%0b with no frame pending", frame_done, frame_abort);
        end else begin
          mon_e = exp_q.pop_front();
          mon_o = obs_q.pop_front();
          check("frame_kind", frame_abort, mon_e.is_abort);
          check("frame_data", mon_o, mon_e.bits);
          check("underrun_cnt", ucnt, mon_e.under);
        end
        ucnt = 0;
      end
    end
  end

  initial begin
    int nf, t;
    bit vs;
    tick(3);
    hrst = 1'b0;
    tick(1);
    check("rst_sdata", sdata, 0);
    check("rst_oe", sdata_oe, 0);
    check("rst_rdy", smp_rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_abort", frame_abort, 0);
    check("rst_underrun", underrun, 0);

    frame(16, 0, '0);              // empty after reset: zeros with underrun
    load(12'hA5C);
    frame(16, 0, '0);
    load(12'h123);
    frame(16, 0, '0);
    frame(16, 0, '0);              // resend 123 with underrun
    load(12'hFFF);
    frame(9, 0, '0);               // abort mid-data
    load(12'h001);
    frame(16, 0, '0);

    for (int i = 0; i < 10; i++) begin
      sclk = ~sclk;
      tick(half);
      check("idle_sclk_sdata", {busy, sdata_oe, sdata}, 3'b000);
    end
    sclk = 1'b1;
    tick(half);
    load(12'h5A6);
    frame(16, 0, '0);

    frame(16, 1, 12'h7E1);         // word offered on the start cycle
    frame(20, 0, '0);              // sends 7E1, trailing falls stay 0

    load(12'h3C3);
    cs_n = 1'b0;
    tick(half);
    for (int i = 0; i < 7; i++) begin
      sclk = 1'b0;
      tick(half);
      sclk = 1'b1;
      tick(half);
    end
    hrst = 1'b1;
    #1;
    check("hrst_outputs", {sdata, sdata_oe, busy, frame_done, frame_abort, underrun}, 6'b0);
    check("hrst_rdy", smp_rdy, 1);
    cs_n = 1'b1;
    sclk = 1'b1;
    tick(2);
    hrst   = 1'b0;
    m_full = 1'b0;
    m_last = '0;
    tick(2);
    frame(16, 0, '0);              // last_smp cleared by reset

    for (int i = 0; i < 40; i++) begin
      half = $urandom_range(4, 7);
      if (!m_full && $urandom_range(0, 2) != 0) load(DATA_W'($urandom));
      nf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(16, 20));
      vs = !m_full && ($urandom_range(0, 3) == 0);
      frame(nf, vs, DATA_W'($urandom));
    end

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      tick(1);
      t++;
    end
    check("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
